// File: rtl/conv3x3_stream_if.sv
// Pixel stream bundle: input stream (s_*) into the engine, output stream (m_*) out of it.
// The engine uses the slave view; the environment driving it uses the master view.
interface conv3x3_stream_if #(
  parameter int DATA_W = 8
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with zero-padded borders, two line buffers and a
// runtime-programmable signed kernel; output is shifted and clamped to pixel range.
module conv3x3_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 4,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int SHIFT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  conv3x3_stream_if.slave          bus,
  output logic                     busy,
  output logic                     done
);

  localparam int XW    = $clog2(IMG_W + 1);
  localparam int YW    = $clog2(IMG_H + 1);
  localparam int ACC_W = DATA_W + COEF_W + 5;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << DATA_W) - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]               state;
  logic [XW-1:0]            vx;
  logic [YW-1:0]            vy;
  logic                     flushed;
  logic signed [COEF_W-1:0] coef [9];

  logic [DATA_W-1:0] lb1 [IMG_W+1];
  logic [DATA_W-1:0] lb2 [IMG_W+1];
  logic [DATA_W-1:0] w1 [3];
  logic [DATA_W-1:0] w2 [3];
  logic [DATA_W-1:0] nc [3];
  logic [DATA_W-1:0] tap [9];

  logic                    real_pos, slot_free, step, emit;
  logic [DATA_W-1:0]       sample;
  logic signed [ACC_W-1:0] prod [9];
  logic signed [ACC_W-1:0] acc, shifted;
  logic [DATA_W-1:0]       result;

  always_comb begin
    real_pos    = (vx < XW'(IMG_W)) && (vy < YW'(IMG_H));
    slot_free   = !bus.m_valid || bus.m_ready;
    bus.s_ready = (state == ST_RUN) && !flushed && real_pos && slot_free;
    step        = (state == ST_RUN) && !flushed && slot_free && (!real_pos || bus.s_valid);
    emit        = step && (vx != '0) && (vy != '0);
    busy        = (state == ST_RUN);
    done        = (state == ST_DONE);
    sample      = real_pos ? bus.s_data : '0;

    // Rows above the frame may hold stale line-buffer data from the last frame.
    nc[0] = (vy > YW'(1)) ? lb2[vx] : '0;
    nc[1] = (vy != '0)    ? lb1[vx] : '0;
    nc[2] = sample;

    for (int unsigned r = 0; r < 3; r++) begin
      tap[r*3]     = (vx == XW'(1)) ? '0 : w1[r];
      tap[r*3 + 1] = w2[r];
      tap[r*3 + 2] = nc[r];
    end

    acc = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      prod[i] = $signed({{(ACC_W-DATA_W){1'b0}}, tap[i]}) *
                $signed({{(ACC_W-COEF_W){coef[i][COEF_W-1]}}, coef[i]});
      acc     = acc + prod[i];
    end
    shifted = acc >>> SHIFT;

    if (shifted[ACC_W-1])   result = '0;
    else if (shifted > MAXV) result = '1;
    else                     result = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      vx          <= '0;
      vy          <= '0;
      flushed     <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      for (int unsigned i = 0; i < 9; i++)
        coef[i] <= (i == 4) ? COEF_W'(4) : ((i % 2) == 1) ? COEF_W'(2) : COEF_W'(1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (coef_we && (coef_addr < 4'd9))
            coef[coef_addr] <= coef_data;
          if (start) begin
            state   <= ST_RUN;
            vx      <= '0;
            vy      <= '0;
            flushed <= 1'b0;
          end
        end
        ST_RUN: begin
          if (step) begin
            if (vx == XW'(IMG_W)) begin
              vx <= '0;
              if (vy == YW'(IMG_H)) flushed <= 1'b1;
              else                  vy      <= vy + 1'b1;
            end else begin
              vx <= vx + 1'b1;
            end
          end
          if (flushed && bus.m_valid && bus.m_ready)
            state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase

      if (emit) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= result;
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end
    end
  end

  // Line buffers and window carry no reset; stale taps are masked above.
  always_ff @(posedge clk) begin
    if (step) begin
      lb1[vx] <= sample;
      lb2[vx] <= lb1[vx];
      w1      <= w2;
      w2      <= nc;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: two instances (SHIFT=4 and SHIFT=0) share all inputs
// and are compared against a direct 2-D convolution model of the frame.
module tb_conv3x3_stream;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              coef_we = 1'b0;
  logic [3:0]        coef_addr = '0;
  logic signed [3:0] coef_data = '0;
  logic              s_valid = 1'b0;
  logic              m_ready = 1'b0;
  logic [7:0]        s_data = '0;
  logic              busy0, done0, busy1, done1;

  int n_cmp = 0;
  int n_bad = 0;
  int img [N];
  int mc [9];

  always #5 clk = ~clk;

  conv3x3_stream_if #(.DATA_W(8)) bus0 ();
  conv3x3_stream_if #(.DATA_W(8)) bus1 ();

  assign bus0.s_valid = s_valid;
  assign bus0.s_data  = s_data;
  assign bus0.m_ready = m_ready;
  assign bus1.s_valid = s_valid;
  assign bus1.s_data  = s_data;
  assign bus1.m_ready = m_ready;

  conv3x3_stream #(.DATA_W(8), .COEF_W(4), .IMG_W(W), .IMG_H(H), .SHIFT(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .bus(bus0), .busy(busy0), .done(done0));

  conv3x3_stream #(.DATA_W(8), .COEF_W(4), .IMG_W(W), .IMG_H(H), .SHIFT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .bus(bus1), .busy(busy1), .done(done1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_pix(input int x, input int y, input int sh);
    int acc = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          acc += mc[(dy + 1) * 3 + (dx + 1)] * img[(y + dy) * W + (x + dx)];
    acc = acc >>> sh;
    if (acc < 0)   return 0;
    if (acc > 255) return 255;
    return acc;
  endfunction

  task automatic default_model_coefs();
    mc = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  endtask

  task automatic set_coef(input int a, input int d);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = 4'(a); coef_data = 4'(d);
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (a < 9) mc[a] = d;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < N; i++) img[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
  endtask

  // rmode 1: m_ready one cycle in three; vmode 1: random s_valid gaps.
  task automatic run_frame(input int rmode, input int vmode, input int abort_at, input bit inject);
    int in_idx = 0, out_idx = 0, cyc = 0;
    bit fin = 1'b0, holding = 1'b0;
    logic [7:0] h0 = '0, h1 = '0;

    @(posedge clk); #1;
    start = 1'b1; s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    @(negedge clk);
    check("idle_done", done0, 0);
    check("idle_busy", busy0, 0);
    check("idle_s_ready", bus0.s_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;

    while (!fin && cyc < 3000) begin
      s_valid = (in_idx < N) && (vmode == 0 || $urandom_range(0, 1) == 1);
      s_data  = (in_idx < N) ? 8'(img[in_idx]) : 8'($urandom);
      m_ready = (rmode == 0) || (cyc % 3 == 0);
      start   = inject && cyc == 7;
      coef_we = inject && cyc == 7;
      coef_addr = 4'd4; coef_data = 4'sd0;
      @(negedge clk);
      if (cyc == 0) check("run_busy", busy0, 1);
      if (holding) begin
        check("hold_valid", bus0.m_valid, 1);
        check("hold_data0", bus0.m_data, h0);
        check("hold_data1", bus1.m_data, h1);
      end
      if (bus0.m_valid && !m_ready) check("full_s_ready", bus0.s_ready, 0);
      if (done0) check("done_early", done0, 0);
      holding = bus0.m_valid && !m_ready;
      h0 = bus0.m_data; h1 = bus1.m_data;
      if (s_valid && bus0.s_ready) in_idx++;
      if (bus0.m_valid && m_ready) begin
        check("pix_shift4", bus0.m_data, ref_pix(out_idx % W, out_idx / W, 4));
        check("pix_shift0", bus1.m_data, ref_pix(out_idx % W, out_idx / W, 0));
        out_idx++;
        if (abort_at > 0 && out_idx == abort_at) begin
          rst = 1'b1; #1;
          check("abort_m_valid", bus0.m_valid, 0);
          check("abort_m_data", bus0.m_data, 0);
          check("abort_busy", busy0, 0);
          check("abort_s_ready", bus0.s_ready, 0);
          check("abort_done", done0, 0);
          s_valid = 1'b0; start = 1'b0; coef_we = 1'b0;
          @(posedge clk); #1;
          rst = 1'b0;
          return;
        end
        if (out_idx == N) fin = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end

    s_valid = 1'b0; start = 1'b0; coef_we = 1'b0;
    check("frame_complete", 32'(fin), 1);
    check("inputs_consumed", in_idx, N);
    check("done_pulse0", done0, 1);
    check("done_pulse1", done1, 1);
    check("done_busy", busy0, 0);
    check("done_m_valid", bus0.m_valid, 0);
  endtask

  initial begin
    #12;
    check("rst_s_ready", bus0.s_ready, 0);
    check("rst_m_valid", bus0.m_valid, 0);
    check("rst_m_data", bus0.m_data, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    default_model_coefs();

    fill_const(100);
    run_frame(0, 0, 0, 1'b0);

    fill_const(0);
    img[1 * W + 1] = 160;
    run_frame(0, 0, 0, 1'b0);

    fill_rand();
    run_frame(1, 1, 0, 1'b0);

    set_coef(0, 0);  set_coef(1, -1); set_coef(2, 0);
    set_coef(3, -1); set_coef(4, 4);  set_coef(5, -1);
    set_coef(6, 0);  set_coef(7, -1); set_coef(8, 0);
    set_coef(12, 5);
    fill_const(50);
    run_frame(0, 0, 0, 1'b0);

    set_coef(4, 7);
    fill_const(255);
    run_frame(0, 0, 0, 1'b0);

    set_coef(4, 4);
    fill_rand();
    run_frame(1, 1, 0, 1'b0);

    fill_rand();
    run_frame(0, 1, 0, 1'b1);

    fill_rand();
    run_frame(0, 0, 5, 1'b0);
    default_model_coefs();

    fill_rand();
    run_frame(0, 0, 0, 1'b0);
    fill_rand();
    run_frame(1, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Streaming 3x3 convolution engine that replaces the frame-buffered blur engine.
- Accepts one raster-order pixel per valid/ready handshake and emits the convolved frame in raster order through a second valid/ready port.
- Uses two internal line buffers instead of a full-frame memory; zero padding at all borders.
- Kernel coefficients are runtime-programmable; normalisation shift, pixel width and frame size are parameters.

Parameters:
- DATA_W, 8, pixel width (unsigned).
- COEF_W, 4, coefficient width (signed two's complement).
- IMG_W, 256, frame width in pixels (>=2).
- IMG_H, 256, frame height in pixels (>=2).
- SHIFT, 4, arithmetic right shift applied to the accumulator.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin one frame; ignored unless idle.
- coef_we  in  1  coefficient write strobe; ignored while busy.
- coef_addr  in  4  coefficient index 0..8, row-major; 9..15 ignored.
- coef_data  in  COEF_W  signed coefficient.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid&&s_ready.
- s_data  in  DATA_W  input pixel.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  output pixel.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on the final output handshake.

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_data=0, busy=0, done=0, state=IDLE, counters=0. Coefficients return to {1,2,1,2,4,2,1,2,1}. Line-buffer contents are don't-care.
- Coefficient write: takes effect the cycle after coef_we when idle. Writes while busy are dropped.
- States: IDLE -> RUN on start. RUN -> DONE after the final output handshake. DONE -> IDLE next cycle. busy=1 in RUN.
- Virtual raster: counters vx in 0..IMG_W and vy in 0..IMG_H step over (IMG_W+1)*(IMG_H+1) positions.
  - Positions with vx<IMG_W and vy<IMG_H are real: they step only on an input handshake.
  - Positions with vx==IMG_W or vy==IMG_H are padding: they step internally with a zero sample and consume no input.
- Stepping is allowed only when the output slot is free (!m_valid || m_ready).
- s_ready = (state==RUN) && real position && slot free.
- Each step shifts the sample into a 3x3 window fed by two line buffers of depth IMG_W+1.
- When vx>=1 and vy>=1, the step produces output pixel (vx-1, vy-1). m_valid rises on the next clock with the registered result; latency is 1 cycle after the step.
- Window taps outside the frame (x<0, y<0, x>=IMG_W, y>=IMG_H) read as 0. The column-0 taps of each row are forced to 0, so there is no wrap from the previous row.
- Arithmetic:
  - Zero-extend pixels and form 9 signed products.
  - Sum in a signed accumulator of DATA_W+COEF_W+5 bits; no internal overflow.
  - Arithmetic shift right by SHIFT (floor toward minus infinity).
  - Clamp to [0, 2^DATA_W-1].
- m_data and m_valid hold stable until m_ready. No bubble is required on back-to-back handshakes.
- Last output pixel (IMG_W-1, IMG_H-1): done=1 for exactly the cycle after its handshake, and busy falls in that same cycle.
- start while busy: ignored. start asserted in the DONE cycle: ignored; a new frame needs start while IDLE.
- s_valid while not in RUN: ignored, s_ready=0.
- Reset mid-frame: all state is abandoned and outputs return to reset values asynchronously. The next frame starts clean once start is seen after reset deasserts.

Test Plan (IMG_W=4, IMG_H=3, default kernel, SHIFT=4):
- Constant frame of 100, m_ready=1 -> corners 56 (900>>4), edges 75, interior 100. Exactly 12 outputs, then done pulses once.
- Impulse of 160 at (1,1), all other pixels 0 -> pixels (0..2, 0..2) equal {10,20,10,20,40,20,10,20,10}; all others 0.
- Coefficients set to {0,-1,0,-1,4,-1,0,-1,0} with SHIFT=0, constant 50 -> interior 0, corner 100, edge 50. With constant 255 and center 7, output clamps to 255 and negative sums clamp to 0.
- m_ready toggled 1-of-3 cycles and s_valid random -> output sequence identical to the free-flowing run; m_data stable while m_valid&&!m_ready; no input is accepted while the output slot is full.
- coef_we and start asserted mid-frame -> both ignored and results unchanged. Assert rst at output 5, then run a new frame -> m_valid drops immediately and the new frame is correct with default coefficients.
- Two frames back-to-back (start during the cycle after DONE) -> second frame results correct, with no row or column contamination from the first frame.
